// File: rtl/audio_out_feeder_pkg.sv
// audio_out_feeder_pkg: shared sample type, output FSM states and default constants.
package audio_out_feeder_pkg;

    typedef logic signed [31:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE
    } state_t;

    localparam int      DEFAULT_SAMPLE_DIV = 1042;
    localparam int      DEFAULT_FIFO_DEPTH = 4;
    localparam sample_t DEFAULT_LIMIT      = 32'sh3FFF_FFFF;

endpackage

// File: rtl/audio_out_feeder_sample_fifo.sv
// sample_fifo: power-of-two sample buffer; a push on a full buffer only lands
// when a pop happens in the same cycle.
module sample_fifo
    import audio_out_feeder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  sample_t data,
    output sample_t head,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);

    sample_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/audio_out_feeder.sv
// audio_out_feeder: samples the oscillator mix once per audio period, attenuates
// and clamps it, buffers it and hands it to the codec through an IDLE/LOAD/WRITE FSM.
module audio_out_feeder
    import audio_out_feeder_pkg::*;
#(
    parameter int      SAMPLE_DIV = DEFAULT_SAMPLE_DIV,
    parameter int      FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter sample_t LIMIT      = DEFAULT_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mix_in,
    input  logic [2:0]  atten,
    input  logic        mute,
    input  logic        audio_out_allowed,
    output logic        write_audio_out,
    output logic [31:0] left_channel_audio_out,
    output logic [31:0] right_channel_audio_out,
    output logic [7:0]  overrun_count
);

    localparam int CW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tick;
    sample_t       sample;
    sample_t       head;
    sample_t       out_reg;
    logic          full;
    logic          empty;
    logic          pop;
    state_t        state;
    state_t        next;

    function automatic sample_t saturate(input sample_t x);
        return x > LIMIT ? LIMIT : (x < -LIMIT ? -LIMIT : x);
    endfunction

    assign tick   = cnt == CW'(SAMPLE_DIV - 1);
    assign sample = mute ? '0 : saturate($signed(mix_in) >>> atten);
    assign pop    = state == LOAD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= tick ? '0 : cnt + CW'(1);
    end

    // The FIFO write on the tick edge is the registered capture of the sample.
    sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tick),
        .pop   (pop),
        .data  (sample),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun_count <= '0;
        else if (tick && full && !pop && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            out_reg <= '0;
        end else begin
            state   <= next;
            out_reg <= pop ? head : out_reg;
        end
    end

    always_comb begin
        next            = state;
        write_audio_out = 1'b0;
        case (state)
            IDLE:  next = empty ? IDLE : LOAD;
            LOAD:  next = WRITE;
            WRITE: begin
                write_audio_out = audio_out_allowed;
                next            = audio_out_allowed ? IDLE : WRITE;
            end
            default: next = IDLE;
        endcase
    end

    assign left_channel_audio_out  = out_reg;
    assign right_channel_audio_out = out_reg;

endmodule

// File: tb/tb_audio_out_feeder.sv
// tb_audio_out_feeder: directed checks of timing, shaping, buffering, overrun and reset.
module tb_audio_out_feeder;

    localparam int SD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] mix_in = '0;
    logic [2:0]  atten = '0;
    logic        mute = 1'b0;
    logic        allowed = 1'b0;
    logic        wao;
    logic [31:0] left;
    logic [31:0] right;
    logic [7:0]  ovr;
    logic        ramp = 1'b0;
    logic [31:0] wl[$];
    logic [31:0] wr[$];
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    audio_out_feeder #(.SAMPLE_DIV(SD), .FIFO_DEPTH(4)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .mix_in                  (mix_in),
        .atten                   (atten),
        .mute                    (mute),
        .audio_out_allowed       (allowed),
        .write_audio_out         (wao),
        .left_channel_audio_out  (left),
        .right_channel_audio_out (right),
        .overrun_count           (ovr)
    );

    always @(negedge clk) begin
        if (rst_n && wao) begin
            wl.push_back(left);
            wr.push_back(right);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ramp)
                mix_in = mix_in + 32'd100;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        wl.delete();
        wr.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_strobe(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (wao) begin
                cnt = i;
                break;
            end
        end
    endtask

    task automatic wait_writes(input int k);
        for (int i = 0; i < 60 && wl.size() < k; i++)
            @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [31:0] m, input logic [2:0] a, input logic mu,
                         input logic [31:0] exp, input string tag);
        mix_in = m;
        atten  = a;
        mute   = mu;
        wait_strobe(n);
        chk({tag, "_left"}, left, exp);
        chk({tag, "_right"}, right, exp);
    endtask

    task automatic chk_q(input string tag, input int i, input logic [31:0] exp);
        chk(tag, wl.size() > i ? wl[i] : 32'hDEAD_BEEF, exp);
        chk({tag, "_r"}, wr.size() > i ? wr[i] : 32'hDEAD_BEEF, exp);
    endtask

    initial begin
        #12;
        chk("rst_wao", 32'(wao), 0);
        chk("rst_left", left, 0);
        chk("rst_right", right, 0);
        chk("rst_ovr", 32'(ovr), 0);

        mix_in = 32'd1000;
        allowed = 1'b1;
        do_reset();
        n = 1;
        for (int i = 0; i < 100 && !wao; i++) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_strobe_cycle", n, SD + 3);
        chk("first_left", left, 1000);
        wait_strobe(n);
        chk("strobe_period", n, SD);
        chk("period_right", right, 1000);

        apply(-32'sd4000, 3'd2, 1'b0, -32'sd1000, "shift2");
        repeat (4) @(posedge clk);
        #1;
        chk("hold_left", left, -32'sd1000);
        wait_strobe(n);
        apply(32'h7FFF_FFFF, 3'd0, 1'b0, 32'h3FFF_FFFF, "sat_pos");
        apply(32'h8000_0000, 3'd0, 1'b0, 32'hC000_0001, "sat_neg");
        apply(32'd1000, 3'd3, 1'b0, 32'd125, "shift3");
        apply(32'hFFFF_FFFF, 3'd7, 1'b0, 32'hFFFF_FFFF, "shift7_neg1");
        apply(32'd5000, 3'd0, 1'b1, 32'd0, "mute");
        mute = 1'b0;

        allowed = 1'b0;
        mix_in  = '0;
        do_reset();
        ramp = 1'b1;
        repeat (52) @(posedge clk);
        #2;
        ramp = 1'b0;
        chk("stall_ovr", 32'(ovr), 1);
        chk("stall_no_writes", wl.size(), 0);
        chk("stall_left", left, 700);
        allowed = 1'b1;
        wait_writes(5);
        chk_q("order0", 0, 700);
        chk_q("order1", 1, 1500);
        chk_q("order2", 2, 2300);
        chk_q("order3", 3, 3100);
        chk_q("order4", 4, 3900);

        allowed = 1'b0;
        do_reset();
        repeat (300 * SD + 10) @(posedge clk);
        #1;
        chk("ovr_saturate", 32'(ovr), 255);

        mix_in = 32'd5000;
        do_reset();
        repeat (20) @(posedge clk);
        #1;
        mute = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        mute = 1'b0;
        allowed = 1'b1;
        wait_writes(4);
        chk_q("mutebuf0", 0, 5000);
        chk_q("mutebuf1", 1, 5000);
        chk_q("mutebuf2", 2, 0);
        chk_q("mutebuf3", 3, 0);

        allowed = 1'b0;
        mix_in = 32'd1000;
        do_reset();
        repeat (12) @(posedge clk);
        #1;
        chk("inwrite_wao", 32'(wao), 0);
        chk("inwrite_left", left, 1000);
        #2;
        rst_n = 1'b0;
        allowed = 1'b1;
        #1;
        chk("midrst_wao", 32'(wao), 0);
        chk("midrst_left", left, 0);
        chk("midrst_right", right, 0);
        @(negedge clk);
        @(negedge clk);
        wl.delete();
        wr.delete();
        rst_n = 1'b1;
        n = 1;
        for (int i = 0; i < 100 && !wao; i++) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rst_strobe_cycle", n, SD + 3);
        chk("rst_strobe_left", left, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1);
    end

endmodule

// File: doc/audio_out_feeder.md
AUDIO_OUT_FEEDER -- requirements
Module: audio_out_feeder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter SAMPLE_DIV, default 1042, giving clock cycles per audio sample period (50 MHz / 48 kHz).
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4, giving sample buffer entries (power of two).
REQ-004 The block SHALL have parameter LIMIT, default 32'sh3FFF_FFFF, giving the symmetric saturation bound ±LIMIT.
REQ-005 clock  input  1  system clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 mix_in  input  32  signed summed square-wave mix from the note oscillator bank.
REQ-008 atten  input  3  arithmetic right-shift amount applied to mix_in, 0..7.
REQ-009 mute  input  1  when 1, captured samples are forced to 0.
REQ-010 audio_out_allowed  input  1  codec output FIFO has space.
REQ-011 write_audio_out  output  1  write strobe to codec, one cycle per sample.
REQ-012 left_channel_audio_out  output  32  signed sample to codec.
REQ-013 right_channel_audio_out  output  32  signed sample, always equal to the left channel.
REQ-014 overrun_count  output  8  saturating count of samples dropped on a full buffer.

Function
REQ-015 The tick counter SHALL count 0..SAMPLE_DIV-1 and wrap to 0, asserting an internal tick for one cycle when count==SAMPLE_DIV-1.
REQ-016 On tick, sample = mute ? 0 : clamp(mix_in >>> atten, -LIMIT, +LIMIT), using a signed arithmetic shift.
REQ-017 The sample SHALL be pushed into the FIFO on the cycle after tick (registered capture).
REQ-018 A push onto a full FIFO with no pop in the same cycle SHALL drop the sample and increment overrun_count, which saturates at 255.
REQ-019 A push and a pop in the same cycle SHALL both succeed, full or not.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-021 Output FSM states SHALL be IDLE, LOAD and WRITE.
REQ-022 IDLE -> LOAD when the FIFO is not empty; otherwise stay in IDLE.
REQ-023 LOAD SHALL pop the FIFO head into the output register driving both channels, then go to WRITE.
REQ-024 In WRITE, write_audio_out = audio_out_allowed (combinational AND with state==WRITE); go to IDLE when write_audio_out is 1, else stay in WRITE.
REQ-025 Channel outputs SHALL hold their value from LOAD until the next LOAD.
REQ-026 Latency: tick at cycle T, empty FIFO, allowed=1 -> FIFO write at T+1, LOAD at T+2, write_audio_out=1 at T+3.
REQ-027 Minimum spacing between writes SHALL be 3 cycles (IDLE/LOAD/WRITE), far below SAMPLE_DIV, so there is no steady-state overrun.
REQ-028 Changes to atten or mute SHALL affect only samples captured afterwards, never buffered samples.

Reset
REQ-029 Asserting reset (0) SHALL immediately clear the tick counter, FIFO pointers, occupancy and overrun_count, and set state to IDLE.
REQ-030 Under reset, write_audio_out=0 and both channel outputs are 0.
REQ-031 Reset mid-WRITE SHALL abandon the pending sample with no write strobe.
REQ-032 After release, the first tick occurs SAMPLE_DIV cycles later.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE/LOAD/WRITE), the default SAMPLE_DIV and LIMIT constants, and the 32-bit signed sample type.
REQ-034 The FIFO SHALL be a single sub-module, sample_fifo (push, pop, data, full, empty), instantiated once.
REQ-035 The saturation function SHALL be implemented in-module.

Verification
REQ-036 SAMPLE_DIV=8, allowed=1, mix_in=1000, atten=0 -> write_audio_out pulses every 8 cycles; first pulse 3 cycles after the first tick; left=right=1000.
REQ-037 mix_in=-4000, atten=2 -> output -1000; mix_in=32'sh7FFF_FFFF, atten=0 -> output 32'sh3FFF_FFFF; mix_in=32'sh8000_0000 -> output -32'sh3FFF_FFFF.
REQ-038 allowed=0 for 6 ticks with FIFO_DEPTH=4 -> 1 sample in the output register plus 4 buffered, overrun_count=1; raise allowed -> 5 writes in original order.
REQ-039 Hold allowed=0 for 300 ticks -> overrun_count stays at 255.
REQ-040 mute=1 with mix_in=5000 -> output 0; toggle mute while samples are buffered -> buffered values are unchanged.
REQ-041 Assert reset in WRITE with allowed=0 -> outputs 0, no strobe; after release the first strobe comes SAMPLE_DIV+3 cycles later.
